// File: rtl/ldpc_wb_pkg.sv
// Shared encodings for the LDPC CSR Wishbone host: command ops, response status,
// FSM states and the width of the register offset spliced under BASE_ADDR.
package ldpc_wb_pkg;

  localparam int unsigned ADR_W = 13;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_BUSERR = 2'b01;
  localparam logic [1:0] ST_POLLX  = 2'b10;
  localparam logic [1:0] ST_TMO    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StGap,
    StRsp
  } wb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ldpc_wb_watchdog.sv
// Loadable down-counter; expire_o flags the last enabled cycle of the loaded budget.
module ldpc_wb_watchdog #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A budget of N expires at the end of the N-th enabled cycle (0 behaves as 1).
  assign expire_o = en_i && (cnt_q <= W'(1));

endmodule

// File: rtl/ldpc_wb_host.sv
// Wishbone B4 pipelined initiator turning single write/read/poll commands into bus
// cycles towards the LDPC CSR block. Optional bus watchdog: LDPC_WB_TIMEOUT_EN.
module ldpc_wb_host
  import ldpc_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
  parameter logic [15:0] POLL_MAX    = 16'd1023,
  parameter logic [15:0] TIMEOUT_CYC = 16'd255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // Command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADR_W-1:0]  cmd_adr,
  input  logic [31:0]       cmd_dat,
  input  logic [31:0]       cmd_mask,
  input  logic [3:0]        cmd_sel,
  // Response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_dat,
  output logic [1:0]        rsp_status,
  output logic [15:0]       rsp_polls,
  // Wishbone initiator
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_stall_i
);

  localparam logic [15:0] PollLim = (POLL_MAX == 16'd0) ? 16'd1 : POLL_MAX;

  wb_state_e   state_q;
  logic [1:0]  op_q;
  logic [31:0] mask_q;
  logic [15:0] cnt_q;

  logic        accept;
  logic        bus_done;
  logic        tmo;
  logic [15:0] cnt_eff;
  logic        poll_hit;
  logic        fin_gap;
  logic [1:0]  fin_status;
  logic [31:0] fin_dat;
  logic [15:0] fin_polls;

`ifdef LDPC_WB_TIMEOUT_EN
  logic wd_load;
  logic wd_en;

  // Budget restarts on every entry into REQ (new command or next poll read).
  assign wd_load = ((state_q == StIdle) && cmd_valid) || (state_q == StGap);
  assign wd_en   = (state_q == StReq) || (state_q == StWait);

  ldpc_wb_watchdog #(
    .W (16)
  ) u_watchdog (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (wd_load),
    .load_val_i (TIMEOUT_CYC),
    .en_i       (wd_en),
    .expire_o   (tmo)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  assign cmd_ready = (state_q == StIdle) && !wb_rst_i;
  assign accept    = (state_q == StReq) && !wbm_stall_i;
  // A response only counts while a request is outstanding (accepting REQ cycle or WAIT).
  assign bus_done  = (accept || (state_q == StWait)) && (wbm_ack_i || wbm_err_i);

  // Decide what a completing bus response turns into.
  always_comb begin
    cnt_eff = cnt_q;
    if ((state_q == StReq) && (op_q != OP_WR)) begin
      cnt_eff = sat_inc16(cnt_q);
    end
    poll_hit   = ((wbm_dat_i ^ wbm_dat_o) & mask_q) == 32'd0;
    fin_gap    = 1'b0;
    fin_status = ST_OK;
    fin_dat    = (op_q == OP_WR) ? 32'd0 : wbm_dat_i;
    fin_polls  = (op_q == OP_WR) ? 16'd1 : cnt_eff;
    if (wbm_err_i) begin
      fin_status = ST_BUSERR;
      fin_dat    = 32'd0;
    end else if ((op_q == OP_POLL) && !poll_hit) begin
      if (cnt_eff == PollLim) begin
        fin_status = ST_POLLX;
      end else begin
        fin_gap = 1'b1;
      end
    end
  end

  // Main FSM; every Wishbone and response output is a register updated here.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      op_q       <= OP_WR;
      mask_q     <= '0;
      cnt_q      <= '0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      rsp_polls  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q      <= (cmd_op == 2'b11) ? OP_RD : cmd_op;
            mask_q    <= cmd_mask;
            cnt_q     <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= (cmd_op == OP_WR);
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= {BASE_ADDR[31:ADR_W], cmd_adr};
            wbm_dat_o <= cmd_dat;
            state_q   <= StReq;
          end
        end
        StReq, StWait: begin
          if (tmo) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_TMO;
            rsp_polls  <= (op_q == OP_WR) ? 16'd1 : cnt_q;
            state_q    <= StRsp;
          end else if (accept || (state_q == StWait)) begin
            wbm_stb_o <= 1'b0;
            cnt_q     <= cnt_eff;
            if (!bus_done) begin
              state_q <= StWait;
            end else if (fin_gap) begin
              wbm_cyc_o <= 1'b0;
              state_q   <= StGap;
            end else begin
              wbm_cyc_o  <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_dat    <= fin_dat;
              rsp_status <= fin_status;
              rsp_polls  <= fin_polls;
              state_q    <= StRsp;
            end
          end
        end
        StGap: begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          state_q   <= StReq;
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_wb_host.sv
// Directed bench for ldpc_wb_host with a scripted Wishbone responder.
// A second instance with POLL_MAX=3 covers poll exhaustion.
module tb_ldpc_wb_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic        cmd_ready, cmd_ready2;
  logic [1:0]  cmd_op = 2'b00;
  logic [12:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0, cmd_mask = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_valid2;
  logic        rsp_ready = 1'b0, rsp_ready2 = 1'b0;
  logic [31:0] rsp_dat, rsp_dat2;
  logic [1:0]  rsp_status, rsp_status2;
  logic [15:0] rsp_polls, rsp_polls2;
  logic        cyc, stb, we, cyc2, stb2, we2;
  logic [3:0]  sel, sel2;
  logic [31:0] adr, dat_o, adr2, dat_o2;
  logic [31:0] wb_dat = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_stall = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ldpc_wb_host #(
    .BASE_ADDR   (32'h3001_0000),
    .POLL_MAX    (16'd1023),
    .TIMEOUT_CYC (16'd8)
  ) dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op), .cmd_adr (cmd_adr),
    .cmd_dat (cmd_dat), .cmd_mask (cmd_mask), .cmd_sel (cmd_sel),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_dat (rsp_dat),
    .rsp_status (rsp_status), .rsp_polls (rsp_polls),
    .wbm_cyc_o (cyc), .wbm_stb_o (stb), .wbm_we_o (we), .wbm_sel_o (sel),
    .wbm_adr_o (adr), .wbm_dat_o (dat_o), .wbm_dat_i (wb_dat),
    .wbm_ack_i (wb_ack), .wbm_err_i (wb_err), .wbm_stall_i (wb_stall)
  );

  // Second instance: zero-wait responder that always returns 0.
  ldpc_wb_host #(
    .BASE_ADDR   (32'h3001_0000),
    .POLL_MAX    (16'd3),
    .TIMEOUT_CYC (16'd8)
  ) dut2 (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .cmd_valid (cmd_valid2), .cmd_ready (cmd_ready2), .cmd_op (cmd_op), .cmd_adr (cmd_adr),
    .cmd_dat (cmd_dat), .cmd_mask (cmd_mask), .cmd_sel (cmd_sel),
    .rsp_valid (rsp_valid2), .rsp_ready (rsp_ready2), .rsp_dat (rsp_dat2),
    .rsp_status (rsp_status2), .rsp_polls (rsp_polls2),
    .wbm_cyc_o (cyc2), .wbm_stb_o (stb2), .wbm_we_o (we2), .wbm_sel_o (sel2),
    .wbm_adr_o (adr2), .wbm_dat_o (dat_o2), .wbm_dat_i (32'd0),
    .wbm_ack_i (stb2), .wbm_err_i (1'b0), .wbm_stall_i (1'b0)
  );

  // Responder script for dut: stall cycles, wait cycles after acceptance, data.
  int          rs_stall = 0;
  int          rs_wait = 0;
  bit          rs_both = 1'b0;
  bit          rs_noack = 1'b0;
  logic [31:0] rs_dat = '0;
  logic [31:0] rd_q[$];
  int          st_left = 0;
  int          wt_left = 0;
  bit          pend = 1'b0;

  task automatic resp_now();
    wb_ack = 1'b1;
    wb_err = rs_both;
    if (rd_q.size() > 0) wb_dat = rd_q.pop_front();
    else wb_dat = rs_dat;
  endtask

  always @(negedge clk) begin
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_stall = 1'b0;
    if (rst || !cyc) begin
      pend    = 1'b0;
      st_left = rs_stall;
    end else if (rs_noack) begin
      pend = 1'b0;
    end else if (stb && st_left > 0) begin
      wb_stall = 1'b1;
      st_left--;
    end else if (stb) begin
      if (rs_wait == 0) resp_now();
      else begin
        pend    = 1'b1;
        wt_left = rs_wait;
      end
    end else if (pend) begin
      wt_left--;
      if (wt_left == 0) begin
        pend = 1'b0;
        resp_now();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Offer one command; returns #1 after the accepting edge T (i.e. in cycle T+1).
  task automatic issue(input bit second, input logic [1:0] op, input logic [12:0] a,
                       input logic [31:0] d, input logic [31:0] m, input logic [3:0] s);
    @(negedge clk);
    cmd_op = op; cmd_adr = a; cmd_dat = d; cmd_mask = m; cmd_sel = s;
    if (second) cmd_valid2 = 1'b1;
    else cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
  endtask

  // lat is the cycle index (relative to T) in which rsp_valid is first high.
  task automatic wait_rsp(input bit second, output int lat);
    int n = 0;
    while (((second ? rsp_valid2 : rsp_valid) !== 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n + 1;
    chk("rsp_arrives", {31'd0, second ? rsp_valid2 : rsp_valid}, 32'd1);
  endtask

  task automatic consume(input bit second);
    @(negedge clk);
    if (second) rsp_ready2 = 1'b1;
    else rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready  = 1'b0;
    rsp_ready2 = 1'b0;
    chk("rsp_dropped", {31'd0, second ? rsp_valid2 : rsp_valid}, 32'd0);
    chk("ready_again", {31'd0, second ? cmd_ready2 : cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          lat;
    logic [6:0]  tr;
    logic [31:0] hold_dat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_polls", {16'd0, rsp_polls}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Write, zero-wait responder; responder data must not leak into rsp_dat
    rs_dat = 32'h5555_AAAA;
    issue(1'b0, 2'b00, 13'h010, 32'h0000_0001, 32'h0, 4'hF);
    chk("wr_stb", {31'd0, stb}, 32'd1);
    chk("wr_adr", adr, 32'h3001_0010);
    chk("wr_we", {31'd0, we}, 32'd1);
    chk("wr_dat", dat_o, 32'h0000_0001);
    chk("wr_sel", {28'd0, sel}, 32'hF);
    chk("wr_busy", {31'd0, cmd_ready}, 32'd0);
    wait_rsp(1'b0, lat);
    chk("wr_latency", lat, 32'd2);
    chk("wr_status", {30'd0, rsp_status}, 32'd0);
    chk("wr_polls", {16'd0, rsp_polls}, 32'd1);
    chk("wr_rsp_dat", rsp_dat, 32'd0);
    chk("wr_cyc_dropped", {31'd0, cyc}, 32'd0);
    consume(1'b0);

    // Read with two stall cycles and one wait cycle
    rs_stall = 2; rs_wait = 1; rs_dat = 32'hDEAD_BEEF;
    issue(1'b0, 2'b01, 13'h004, 32'h0, 32'h0, 4'hF);
    chk("rd_we", {31'd0, we}, 32'd0);
    chk("rd_adr", adr, 32'h3001_0004);
    wait_rsp(1'b0, lat);
    chk("rd_latency", lat, 32'd5);
    chk("rd_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("rd_status", {30'd0, rsp_status}, 32'd0);
    chk("rd_polls", {16'd0, rsp_polls}, 32'd1);
    consume(1'b0);

    // Reserved op behaves as a read
    rs_stall = 0; rs_wait = 0; rs_dat = 32'h1234_5678;
    issue(1'b0, 2'b11, 13'h008, 32'hFFFF_FFFF, 32'h0, 4'h3);
    chk("resv_we", {31'd0, we}, 32'd0);
    wait_rsp(1'b0, lat);
    chk("resv_dat", rsp_dat, 32'h1234_5678);
    consume(1'b0);

    // Poll success on 4th read; cyc low for exactly one cycle between reads
    rd_q = '{32'h0, 32'h0, 32'h0, 32'h1};
    issue(1'b0, 2'b10, 13'h00C, 32'h1, 32'h1, 4'hF);
    tr = '0;
    for (int i = 0; i < 7; i++) begin
      tr = {tr[5:0], cyc};
      @(posedge clk); #1;
    end
    chk("poll_cyc_trace", {25'd0, tr}, 32'h55);
    chk("poll_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("poll_status", {30'd0, rsp_status}, 32'd0);
    chk("poll_polls", {16'd0, rsp_polls}, 32'd4);
    chk("poll_dat", rsp_dat, 32'h1);
    consume(1'b0);

    // Poll exhaustion on the POLL_MAX=3 instance
    issue(1'b1, 2'b10, 13'h00C, 32'h1, 32'h1, 4'hF);
    wait_rsp(1'b1, lat);
    chk("px_latency", lat, 32'd6);
    chk("px_status", {30'd0, rsp_status2}, 32'd2);
    chk("px_polls", {16'd0, rsp_polls2}, 32'd3);
    chk("px_dat", rsp_dat2, 32'd0);
    consume(1'b1);

    // ack+err together; response held under backpressure
    rs_both = 1'b1; rs_dat = 32'hCAFE_0000;
    issue(1'b0, 2'b01, 13'h020, 32'h0, 32'h0, 4'hF);
    wait_rsp(1'b0, lat);
    chk("err_status", {30'd0, rsp_status}, 32'd1);
    hold_dat = rsp_dat;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("err_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("err_hold_status", {30'd0, rsp_status}, 32'd1);
      chk("err_hold_dat", rsp_dat, hold_dat);
      chk("err_hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    consume(1'b0);
    rs_both = 1'b0;

    // Reset while in WAIT
    rs_wait = 3; rs_dat = 32'h0BAD_0BAD;
    issue(1'b0, 2'b01, 13'h030, 32'h0, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("pre_rst_in_wait", {30'd0, cyc, stb}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cyc", {31'd0, cyc}, 32'd0);
    chk("mid_rst_stb", {31'd0, stb}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("mid_rst_idle", {31'd0, cmd_ready}, 32'd1);
    rs_wait = 0;

`ifdef LDPC_WB_TIMEOUT_EN
    // Responder never acks
    rs_noack = 1'b1;
    issue(1'b0, 2'b01, 13'h040, 32'h0, 32'h0, 4'hF);
    wait_rsp(1'b0, lat);
    chk("tmo_status", {30'd0, rsp_status}, 32'd3);
    chk("tmo_dat", rsp_dat, 32'd0);
    chk("tmo_cyc", {31'd0, cyc}, 32'd0);
    rs_noack = 1'b0;
    consume(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
